// File: rtl/reg_seq.sv
// rtl/reg_seq.sv - four-state register-file instruction sequencer
//
// Purpose: accepts one LDI/ADD/SUB/MOV instruction at a time, reads its
// operands from an external register file one per cycle, and writes the
// result back in a single write-back cycle.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   instr_valid/instr_ready   instruction handshake
//   instr_op/rd/ra/rb/imm     instruction fields, latched on handshake
//   rf_rsel, rf_q             register-file read select / read data
//   rf_en, rf_wsel, rf_d      register-file write enable / select / data
//   done                      one-cycle pulse in the write-back cycle
//   carry                     ADD carry-out / SUB borrow flag
module reg_seq #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        instr_op,
   input  logic [1:0]        instr_rd,
   input  logic [1:0]        instr_ra,
   input  logic [1:0]        instr_rb,
   input  logic [DATA_W-1:0] instr_imm,
   input  logic [DATA_W-1:0] rf_q,
   output logic [1:0]        rf_rsel,
   output logic              rf_en,
   output logic [1:0]        rf_wsel,
   output logic [DATA_W-1:0] rf_d,
   output logic              done,
   output logic              carry
);

   typedef enum logic [1:0] {IDLE, RDA, RDB, WB} state_t;

   localparam logic [1:0] OP_LDI = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_MOV = 2'b11;

   state_t            state;
   logic [1:0]        op_q;
   logic [1:0]        rd_q;
   logic [1:0]        ra_q;
   logic [1:0]        rb_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic              carry_q;

   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] diff;
   logic              borrow;
   logic [DATA_W-1:0] wb_data;
   logic              in_wb;

   assign sum    = {1'b0, opa} + {1'b0, opb};
   assign diff   = opa - opb;
   assign borrow = (opa < opb);

   always_comb begin
      wb_data = '0;
      case (op_q)
         OP_LDI:  wb_data = imm_q;
         OP_ADD:  wb_data = sum[DATA_W-1:0];
         OP_SUB:  wb_data = diff;
         default: wb_data = opa;
      endcase
   end

   // Outputs are decoded from the state register and forced quiet while rst
   // is high, so a reset raised during WB suppresses the pending write.
   assign in_wb       = (state == WB) && !rst;
   assign instr_ready = (state == IDLE) && !rst;
   assign rf_en       = in_wb;
   assign done        = in_wb;
   assign rf_wsel     = in_wb ? rd_q : 2'b00;
   assign rf_d        = in_wb ? wb_data : '0;
   assign rf_rsel     = rst            ? 2'b00 :
                        (state == RDA) ? ra_q  :
                        (state == RDB) ? rb_q  : 2'b00;
   assign carry       = carry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= '0;
         rd_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         imm_q   <= '0;
         opa     <= '0;
         opb     <= '0;
         carry_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  op_q  <= instr_op;
                  rd_q  <= instr_rd;
                  ra_q  <= instr_ra;
                  rb_q  <= instr_rb;
                  imm_q <= instr_imm;
                  state <= (instr_op == OP_LDI) ? WB : RDA;
               end
            end
            RDA: begin
               opa   <= rf_q;
               state <= (op_q == OP_MOV) ? WB : RDB;
            end
            RDB: begin
               opb   <= rf_q;
               state <= WB;
            end
            WB: begin
               if (op_q == OP_ADD)
                  carry_q <= sum[DATA_W];
               else if (op_q == OP_SUB)
                  carry_q <= borrow;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_seq.sv
// tb/tb_reg_seq.sv - self-checking bench for reg_seq
module tb_reg_seq;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  instr_op;
   logic [1:0]  instr_rd;
   logic [1:0]  instr_ra;
   logic [1:0]  instr_rb;
   logic [15:0] instr_imm;
   logic [15:0] rf_q;
   logic [1:0]  rf_rsel;
   logic        rf_en;
   logic [1:0]  rf_wsel;
   logic [15:0] rf_d;
   logic        done;
   logic        carry;

   int nvec = 0;
   int nmis = 0;
   bit chk_en = 0;

   reg_seq #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
      .instr_rb(instr_rb), .instr_imm(instr_imm),
      .rf_q(rf_q), .rf_rsel(rf_rsel),
      .rf_en(rf_en), .rf_wsel(rf_wsel), .rf_d(rf_d),
      .done(done), .carry(carry)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // External register file the sequencer drives.
   logic [15:0] env_rf [4] = '{default: 16'h0000};
   assign rf_q = env_rf[rf_rsel];
   always @(posedge clk) if (rf_en) env_rf[rf_wsel] <= rf_d;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: per-instruction latency table and register contents.
   logic [15:0] mrf [4] = '{default: 16'h0000};
   bit          m_active = 0;
   int          m_start  = 0;
   int          cyc      = 0;
   logic [1:0]  m_op, m_rd, m_ra, m_rb;
   logic [15:0] m_res;
   bit          m_c;
   bit          m_carry = 0;

   always @(negedge clk) begin
      int          k;
      int          lat;
      logic        e_ready, e_en, e_done;
      logic [1:0]  e_rsel, e_wsel;
      logic [15:0] e_d;
      logic [16:0] wide;
      k   = cyc - m_start;
      lat = (m_op == 2'b00) ? 1 : (m_op == 2'b11) ? 2 : 3;
      e_ready = !m_active && !rst;
      e_en = 0; e_done = 0; e_rsel = 0; e_wsel = 0; e_d = 0;
      if (m_active && !rst) begin
         if (k == lat) begin
            e_en = 1; e_done = 1; e_wsel = m_rd; e_d = m_res;
         end else if (k == 1) begin
            e_rsel = m_ra;
         end else if (k == 2) begin
            e_rsel = m_rb;
         end
      end
      if (chk_en) begin
         chk("instr_ready", 32'(instr_ready), 32'(e_ready));
         chk("rf_rsel",     32'(rf_rsel),     32'(e_rsel));
         chk("rf_en",       32'(rf_en),       32'(e_en));
         chk("rf_wsel",     32'(rf_wsel),     32'(e_wsel));
         chk("rf_d",        32'(rf_d),        32'(e_d));
         chk("done",        32'(done),        32'(e_done));
         chk("carry",       32'(carry),       32'(m_carry));
      end
      if (rst) begin
         m_active = 0;
         m_carry  = 0;
      end else if (m_active && k == lat) begin
         mrf[m_rd] = m_res;
         if (m_op == 2'b01 || m_op == 2'b10) m_carry = m_c;
         m_active = 0;
      end else if (!m_active && instr_valid) begin
         m_op = instr_op; m_rd = instr_rd; m_ra = instr_ra; m_rb = instr_rb;
         m_c  = 0;
         case (instr_op)
            2'b00: m_res = instr_imm;
            2'b01: begin
               wide  = 17'(mrf[instr_ra]) + 17'(mrf[instr_rb]);
               m_res = wide[15:0];
               m_c   = wide[16];
            end
            2'b10: begin
               m_res = mrf[instr_ra] - mrf[instr_rb];
               m_c   = mrf[instr_ra] < mrf[instr_rb];
            end
            default: m_res = mrf[instr_ra];
         endcase
         m_active = 1;
         m_start  = cyc;
      end
      cyc++;
   end

   task automatic set_fields(input logic [1:0] op, input logic [1:0] rd,
                             input logic [1:0] ra, input logic [1:0] rb,
                             input logic [15:0] imm);
      instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
   endtask

   task automatic scramble();
      set_fields(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom));
   endtask

   // Presents an instruction until accepted; returns just after the
   // handshake edge, i.e. early in cycle N+1.
   task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb,
                        input logic [15:0] imm);
      int n;
      n = 0;
      @(posedge clk); #1;
      instr_valid = 1;
      set_fields(op, rd, ra, rb, imm);
      @(negedge clk);
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("issue_timeout", 32'(n), 32'(0));
      @(posedge clk); #1;
      instr_valid = 0;
      scramble();
   endtask

   initial begin
      rst = 1;
      instr_valid = 0;
      set_fields(0, 0, 0, 0, 0);
      @(posedge clk);
      chk_en = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(instr_ready), 32'(0));
      chk("rst_en",    32'(rf_en),       32'(0));
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("post_rst_ready", 32'(instr_ready), 32'(1));
      chk("post_rst_carry", 32'(carry),       32'(0));

      // LDI rd=2 imm=0x1234
      issue(2'b00, 2'd2, 2'd0, 2'd0, 16'h1234);
      @(negedge clk);
      chk("ldi_en",   32'(rf_en),   32'(1));
      chk("ldi_wsel", 32'(rf_wsel), 32'(2));
      chk("ldi_d",    32'(rf_d),    32'(16'h1234));
      chk("ldi_done", 32'(done),    32'(1));
      @(negedge clk);
      chk("ldi_carry", 32'(carry), 32'(0));

      // ADD with carry-out
      issue(2'b00, 2'd0, 2'd0, 2'd0, 16'hFFFF);
      issue(2'b00, 2'd1, 2'd0, 2'd0, 16'h0002);
      issue(2'b01, 2'd3, 2'd0, 2'd1, 16'h0000);
      @(negedge clk);
      chk("add_rsel_a", 32'(rf_rsel), 32'(0));
      @(negedge clk);
      chk("add_rsel_b", 32'(rf_rsel), 32'(1));
      @(negedge clk);
      chk("add_d", 32'(rf_d), 32'(16'h0001));
      @(negedge clk);
      chk("add_carry", 32'(carry), 32'(1));

      // SUB pair with borrow both times
      issue(2'b00, 2'd0, 2'd0, 2'd0, 16'h0005);
      issue(2'b00, 2'd1, 2'd0, 2'd0, 16'h0007);
      issue(2'b10, 2'd0, 2'd0, 2'd1, 16'h0000);
      repeat (3) @(negedge clk);
      chk("sub1_d", 32'(rf_d), 32'(16'hFFFE));
      @(negedge clk);
      chk("sub1_carry", 32'(carry), 32'(1));
      issue(2'b10, 2'd1, 2'd1, 2'd0, 16'h0000);
      repeat (3) @(negedge clk);
      chk("sub2_d", 32'(rf_d), 32'(16'h0009));
      @(negedge clk);
      chk("sub2_carry", 32'(carry), 32'(1));

      // valid held high with changing fields through an ADD (0xFFFE + 0x0009)
      @(posedge clk); #1;
      instr_valid = 1;
      set_fields(2'b01, 2'd3, 2'd0, 2'd1, 16'h0000);
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) chk("hold_timeout", 32'(n), 32'(0));
      end
      @(posedge clk); #1;
      for (int i = 1; i <= 3; i++) begin
         scramble();
         @(negedge clk);
         chk("hold_ready_low", 32'(instr_ready), 32'(0));
         if (i == 3) chk("hold_add_d", 32'(rf_d), 32'(16'h0007));
         @(posedge clk); #1;
      end
      set_fields(2'b00, 2'd2, 2'd0, 2'd0, 16'h5A5A);
      @(negedge clk);
      chk("hold_ready_back", 32'(instr_ready), 32'(1));
      @(posedge clk); #1;
      instr_valid = 0;
      @(negedge clk);
      chk("hold_ldi_d",    32'(rf_d),    32'(16'h5A5A));
      chk("hold_ldi_wsel", 32'(rf_wsel), 32'(2));

      // reset pulsed during RDB
      issue(2'b01, 2'd0, 2'd0, 2'd1, 16'h0000);
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      chk("rdb_rst_en",    32'(rf_en),       32'(0));
      chk("rdb_rst_ready", 32'(instr_ready), 32'(0));
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("after_rst_en",    32'(rf_en),       32'(0));
      chk("after_rst_done",  32'(done),        32'(0));
      chk("after_rst_carry", 32'(carry),       32'(0));
      chk("after_rst_ready", 32'(instr_ready), 32'(1));

      // MOV rd=1 ra=1, then LDI followed by dependent ADD
      issue(2'b11, 2'd1, 2'd1, 2'd0, 16'h0000);
      repeat (2) @(negedge clk);
      chk("mov_en", 32'(rf_en), 32'(1));
      chk("mov_d",  32'(rf_d),  32'(16'h0009));
      issue(2'b00, 2'd2, 2'd0, 2'd0, 16'h00AA);
      issue(2'b01, 2'd3, 2'd2, 2'd2, 16'h0000);
      repeat (3) @(negedge clk);
      chk("dep_add_d", 32'(rf_d), 32'(16'h0154));

      // randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 39) == 0);
         instr_valid = ($urandom_range(0, 3) != 0);
         scramble();
      end
      @(posedge clk); #1;
      rst = 0;
      instr_valid = 0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
